// File: rtl/css5_pkg.sv
// Shared definitions for the [[5,1,3]] code: syndrome columns, axis and Pauli
// encodings, and the frame-to-syndrome function used by hardware and benches.
package css5_pkg;

   localparam int NUM_QUBITS = 5;

   // Column q of each table is the ancilla pattern flipped by an X (SX) or Z (SZ) on qubit q.
   localparam logic [4:0][3:0] SX = {4'b0001, 4'b1000, 4'b1100, 4'b0110, 4'b0011};
   localparam logic [4:0][3:0] SZ = {4'b1010, 4'b0101, 4'b0010, 4'b1001, 4'b0100};

   typedef enum logic [1:0] {
      AXIS_NONE = 2'b00,
      AXIS_X    = 2'b01,
      AXIS_Y    = 2'b10,
      AXIS_Z    = 2'b11
   } axis_e;

   typedef enum logic [1:0] {
      PAULI_I = 2'b00,
      PAULI_Z = 2'b01,
      PAULI_X = 2'b10,
      PAULI_Y = 2'b11
   } pauli_e;

   function automatic logic pauli_has_x(input logic [1:0] p);
      return p[1];
   endfunction

   function automatic logic pauli_has_z(input logic [1:0] p);
      return p[0];
   endfunction

   function automatic logic axis_hits_x(input axis_e a);
      return (a == AXIS_X) || (a == AXIS_Y);
   endfunction

   function automatic logic axis_hits_z(input axis_e a);
      return (a == AXIS_Z) || (a == AXIS_Y);
   endfunction

   function automatic logic [3:0] syndrome(input logic [4:0] fx, input logic [4:0] fz);
      logic [3:0] s;
      s = 4'b0000;
      for (int q = 0; q < NUM_QUBITS; q++) begin
         if (fx[q]) s = s ^ SX[q];
         if (fz[q]) s = s ^ SZ[q];
      end
      return s;
   endfunction

endpackage

// File: rtl/syndrome_frame_gen_if.sv
// Injection handshake plus the ancilla/correction link to the syndrome decoder.
interface syndrome_frame_gen_if;
   logic       err_valid;
   logic       err_ready;
   logic [2:0] err_qubit;
   logic [1:0] err_pauli;
   logic [4:0] correction;
   logic [1:0] axis;
   logic [3:0] ancilla;

   modport master (
      output err_valid, err_qubit, err_pauli, correction, axis,
      input  err_ready, ancilla
   );

   modport slave (
      input  err_valid, err_qubit, err_pauli, correction, axis,
      output err_ready, ancilla
   );
endinterface

// File: rtl/syndrome_calc.sv
// Combinational map from the Pauli frame to its 4-bit ancilla syndrome.
module syndrome_calc
   import css5_pkg::*;
(
   input  logic [4:0] frame_x,
   input  logic [4:0] frame_z,
   output logic [3:0] ancilla
);

   assign ancilla = syndrome(frame_x, frame_z);

endmodule

// File: rtl/syndrome_frame_gen.sv
// Pauli error frame for 5 data qubits: takes injections, emits the syndrome for a
// whole round and folds the decoder's corrections back in at round end.
module syndrome_frame_gen
   import css5_pkg::*;
#(
   parameter int ROUND_LEN   = 5,
   parameter bit FEEDBACK_EN = 1'b1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   syndrome_frame_gen_if.slave  bus,
   output logic [4:0]           frame_x,
   output logic [4:0]           frame_z,
   output logic                 round_start,
   output logic                 clean,
   output logic                 bad_idx,
   output logic [7:0]           corr_count
);

   generate
      if (ROUND_LEN < 5 || ROUND_LEN > 15) begin : g_bad_round_len
         $error("syndrome_frame_gen: ROUND_LEN must be within 5..15");
      end
   endgenerate

   localparam logic [3:0] LAST_PHASE = 4'(ROUND_LEN - 1);

   logic [3:0] phase;
   logic [4:0] pend_x, pend_z;
   logic [4:0] inj_x, inj_z;
   logic       err_ready_q;
   logic [3:0] ancilla_w;

   logic       last_phase;
   logic       collect;
   logic       accept;
   logic       idx_ok;
   logic [4:0] onehot;
   logic [4:0] new_inj_x, new_inj_z;
   logic [4:0] new_pend_x, new_pend_z;
   logic [4:0] fb_x, fb_z;

   assign last_phase  = (phase == LAST_PHASE);
   // Phases 0 and 1 still carry the decoder's answer to the previous round's syndrome.
   assign collect     = (phase >= 4'd2);
   assign accept      = bus.err_valid && err_ready_q;
   assign idx_ok      = (bus.err_qubit <= 3'd4);
   assign onehot      = 5'b00001 << bus.err_qubit;

   assign bus.err_ready = err_ready_q;
   assign round_start   = (phase == 4'd0);
   assign clean         = ~|{frame_x, frame_z};

   always_comb begin
      new_inj_x  = inj_x;
      new_inj_z  = inj_z;
      new_pend_x = pend_x;
      new_pend_z = pend_z;
      if (accept && idx_ok) begin
         if (pauli_has_x(bus.err_pauli)) new_inj_x = inj_x | onehot;
         if (pauli_has_z(bus.err_pauli)) new_inj_z = inj_z | onehot;
      end
      if (collect) begin
         if (axis_hits_x(axis_e'(bus.axis))) new_pend_x = pend_x | bus.correction;
         if (axis_hits_z(axis_e'(bus.axis))) new_pend_z = pend_z | bus.correction;
      end
   end

   assign fb_x = FEEDBACK_EN ? new_pend_x : 5'b00000;
   assign fb_z = FEEDBACK_EN ? new_pend_z : 5'b00000;

   // Injections and corrections gathered during the round (including its last cycle)
   // land together on the edge that leaves the last phase.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         phase       <= 4'd0;
         frame_x     <= 5'b00000;
         frame_z     <= 5'b00000;
         pend_x      <= 5'b00000;
         pend_z      <= 5'b00000;
         inj_x       <= 5'b00000;
         inj_z       <= 5'b00000;
         err_ready_q <= 1'b1;
         bad_idx     <= 1'b0;
         corr_count  <= 8'd0;
      end else begin
         bad_idx <= accept && !idx_ok;
         if (last_phase) begin
            phase       <= 4'd0;
            frame_x     <= frame_x ^ new_inj_x ^ fb_x;
            frame_z     <= frame_z ^ new_inj_z ^ fb_z;
            pend_x      <= 5'b00000;
            pend_z      <= 5'b00000;
            inj_x       <= 5'b00000;
            inj_z       <= 5'b00000;
            err_ready_q <= 1'b1;
            if (FEEDBACK_EN && (|{new_pend_x, new_pend_z}) && (corr_count != 8'hFF))
               corr_count <= corr_count + 8'd1;
         end else begin
            phase  <= phase + 4'd1;
            pend_x <= new_pend_x;
            pend_z <= new_pend_z;
            inj_x  <= new_inj_x;
            inj_z  <= new_inj_z;
            if (accept) err_ready_q <= 1'b0;
         end
      end
   end

   syndrome_calc u_calc (
      .frame_x (frame_x),
      .frame_z (frame_z),
      .ancilla (ancilla_w)
   );

   assign bus.ancilla = ancilla_w;

endmodule

// File: tb/tb_syndrome_frame_gen.sv
// Closed-loop bench: a closed-loop and an open-loop instance share clock and reset;
// round-end snapshots are predicted into a queue and checked at each round start.
module tb_syndrome_frame_gen;

   typedef struct packed {
      logic [4:0] fx;
      logic [4:0] fz;
      logic [3:0] anc;
      logic [7:0] cc;
   } snap_t;

   localparam logic [3:0] BSX [5] = '{4'b0011, 4'b0110, 4'b1100, 4'b1000, 4'b0001};
   localparam logic [3:0] BSZ [5] = '{4'b0100, 4'b1001, 4'b0010, 4'b0101, 4'b1010};

   logic CLK = 1'b0;
   logic RST_N;

   logic [4:0] m_fx, m_fz, o_fx, o_fz;
   logic       m_rs, m_clean, m_bad, o_rs, o_clean, o_bad;
   logic [7:0] m_cc, o_cc;

   int    total = 0;
   int    bad = 0;
   int    exp_cc = 0;
   snap_t exp_q[$];

   syndrome_frame_gen_if m_bus ();
   syndrome_frame_gen_if o_bus ();

   syndrome_frame_gen #(.ROUND_LEN(5), .FEEDBACK_EN(1'b1)) u_dut (
      .CLK (CLK), .RST_N (RST_N), .bus (m_bus),
      .frame_x (m_fx), .frame_z (m_fz), .round_start (m_rs),
      .clean (m_clean), .bad_idx (m_bad), .corr_count (m_cc)
   );

   syndrome_frame_gen #(.ROUND_LEN(5), .FEEDBACK_EN(1'b0)) u_ol (
      .CLK (CLK), .RST_N (RST_N), .bus (o_bus),
      .frame_x (o_fx), .frame_z (o_fz), .round_start (o_rs),
      .clean (o_clean), .bad_idx (o_bad), .corr_count (o_cc)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single-qubit lookup decoder: returns {axis, correction} for a syndrome.
   function automatic logic [6:0] decode(input logic [3:0] s);
      logic [4:0] oh;
      for (int q = 0; q < 5; q++) begin
         oh = 5'(5'b00001 << q);
         if (s == BSX[q])          return {2'b01, oh};
         if (s == (BSX[q] ^ BSZ[q])) return {2'b10, oh};
         if (s == BSZ[q])          return {2'b11, oh};
      end
      return 7'd0;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_round(input bit ol, output snap_t obs);
      int n;
      step();
      n = 0;
      while (!m_rs && n < 40) begin
         step();
         n++;
      end
      if (!m_rs) begin
         total++;
         bad++;
         $display("[TB] FAIL round_timeout got=0 want=1");
      end
      obs.fx  = ol ? o_fx : m_fx;
      obs.fz  = ol ? o_fz : m_fz;
      obs.anc = ol ? o_bus.ancilla : m_bus.ancilla;
      obs.cc  = ol ? o_cc : m_cc;
   endtask

   task automatic push_exp(input logic [4:0] fx, input logic [4:0] fz, input logic [3:0] anc, input int cc);
      snap_t e;
      e.fx  = fx;
      e.fz  = fz;
      e.anc = anc;
      e.cc  = 8'(cc);
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      step();
      step();
      total++; if ({m_fx, m_fz} !== 10'd0) begin bad++; $display("[TB] FAIL reset_frame got=%b want=0", {m_fx, m_fz}); end
      total++; if (m_bus.ancilla !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ancilla got=%b want=0000", m_bus.ancilla); end
      total++; if (m_clean !== 1'b1) begin bad++; $display("[TB] FAIL reset_clean got=%b want=1", m_clean); end
      total++; if (m_bus.err_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_err_ready got=%b want=1", m_bus.err_ready); end
      total++; if (m_bad !== 1'b0) begin bad++; $display("[TB] FAIL reset_bad_idx got=%b want=0", m_bad); end
      total++; if (m_cc !== 8'd0) begin bad++; $display("[TB] FAIL reset_corr_count got=%0d want=0", m_cc); end
      RST_N = 1'b1;
      total++; if (m_rs !== 1'b1) begin bad++; $display("[TB] FAIL reset_round_start got=%b want=1", m_rs); end
   endtask

   task automatic test_idle();
      for (int i = 0; i < 20; i++) begin
         total++;
         if (m_rs !== 1'((i % 5) == 0)) begin
            bad++; $display("[TB] FAIL idle_round_start cycle=%0d got=%b want=%b", i, m_rs, (i % 5) == 0);
         end
         total++;
         if ({m_bus.ancilla, m_clean, m_bus.err_ready} !== 6'b000011) begin
            bad++; $display("[TB] FAIL idle_status cycle=%0d got=%b want=000011", i, {m_bus.ancilla, m_clean, m_bus.err_ready});
         end
         step();
      end
   endtask

   task automatic test_loopback(input string tag, input logic [2:0] q, input logic [1:0] p,
                                input logic [4:0] efx, input logic [4:0] efz, input logic [3:0] eanc);
      snap_t obs, e;
      logic [6:0] d;
      m_bus.err_valid = 1'b1; m_bus.err_qubit = q; m_bus.err_pauli = p;
      step();
      m_bus.err_valid = 1'b0;
      total++; if (m_bus.err_ready !== 1'b0) begin bad++; $display("[TB] FAIL %s_ready_drop got=%b want=0", tag, m_bus.err_ready); end
      push_exp(efx, efz, eanc, exp_cc);
      wait_round(1'b0, obs);
      e = exp_q.pop_front();
      total++; if (obs !== e) begin bad++; $display("[TB] FAIL %s_inject got=%h want=%h", tag, obs, e); end
      d = decode(obs.anc);
      step();
      step();
      {m_bus.axis, m_bus.correction} = d;
      step();
      {m_bus.axis, m_bus.correction} = 7'd0;
      exp_cc++;
      push_exp(5'd0, 5'd0, 4'b0000, exp_cc);
      wait_round(1'b0, obs);
      e = exp_q.pop_front();
      total++; if (obs !== e) begin bad++; $display("[TB] FAIL %s_corrected got=%h want=%h", tag, obs, e); end
   endtask

   task automatic test_open_loop();
      snap_t obs, e;
      o_bus.err_valid = 1'b1; o_bus.err_qubit = 3'd4; o_bus.err_pauli = 2'b10;
      step();
      o_bus.err_valid = 1'b0;
      push_exp(5'b10000, 5'b00000, 4'b0001, 0);
      wait_round(1'b1, obs);
      e = exp_q.pop_front();
      total++; if (obs !== e) begin bad++; $display("[TB] FAIL open_loop_x got=%h want=%h", obs, e); end
      o_bus.err_valid = 1'b1; o_bus.err_qubit = 3'd3; o_bus.err_pauli = 2'b01;
      step();
      o_bus.err_valid = 1'b0;
      step();
      o_bus.axis = 2'b01; o_bus.correction = 5'b10000;
      step();
      o_bus.axis = 2'b00; o_bus.correction = 5'b00000;
      push_exp(5'b10000, 5'b01000, 4'b0100, 0);
      wait_round(1'b1, obs);
      e = exp_q.pop_front();
      total++; if (obs !== e) begin bad++; $display("[TB] FAIL open_loop_xz got=%h want=%h", obs, e); end
   endtask

   task automatic test_window();
      snap_t obs, e;
      m_bus.axis = 2'b01; m_bus.correction = 5'b10000;
      step();
      step();
      m_bus.axis = 2'b00; m_bus.correction = 5'b00000;
      push_exp(5'd0, 5'd0, 4'b0000, exp_cc);
      wait_round(1'b0, obs);
      e = exp_q.pop_front();
      total++; if (obs !== e) begin bad++; $display("[TB] FAIL window_phase01 got=%h want=%h", obs, e); end
   endtask

   task automatic test_last_phase();
      snap_t obs, e;
      for (int i = 0; i < 4; i++) step();
      m_bus.err_valid = 1'b1; m_bus.err_qubit = 3'd0; m_bus.err_pauli = 2'b10;
      step();
      m_bus.err_valid = 1'b0;
      total++; if (m_bus.err_ready !== 1'b1) begin bad++; $display("[TB] FAIL last_phase_ready got=%b want=1", m_bus.err_ready); end
      push_exp(5'b00001, 5'b00000, 4'b0011, exp_cc);
      wait_round(1'b0, obs);
      e = exp_q.pop_front();
      total++; if (obs !== e) begin bad++; $display("[TB] FAIL last_phase_inject got=%h want=%h", obs, e); end
      for (int i = 0; i < 4; i++) step();
      m_bus.axis = 2'b01; m_bus.correction = 5'b00001;
      step();
      m_bus.axis = 2'b00; m_bus.correction = 5'b00000;
      exp_cc++;
      push_exp(5'd0, 5'd0, 4'b0000, exp_cc);
      wait_round(1'b0, obs);
      e = exp_q.pop_front();
      total++; if (obs !== e) begin bad++; $display("[TB] FAIL last_phase_correct got=%h want=%h", obs, e); end
   endtask

   task automatic test_bad_idx();
      snap_t obs, e;
      m_bus.err_valid = 1'b1; m_bus.err_qubit = 3'd5; m_bus.err_pauli = 2'b10;
      step();
      total++; if ({m_bad, m_bus.err_ready} !== 2'b10) begin bad++; $display("[TB] FAIL bad_idx_pulse got=%b want=10", {m_bad, m_bus.err_ready}); end
      m_bus.err_qubit = 3'd2;
      step();
      total++; if ({m_bad, m_bus.err_ready} !== 2'b00) begin bad++; $display("[TB] FAIL bad_idx_second got=%b want=00", {m_bad, m_bus.err_ready}); end
      m_bus.err_valid = 1'b0;
      push_exp(5'd0, 5'd0, 4'b0000, exp_cc);
      wait_round(1'b0, obs);
      e = exp_q.pop_front();
      total++; if (obs !== e) begin bad++; $display("[TB] FAIL bad_idx_frame got=%h want=%h", obs, e); end
      total++; if (m_bus.err_ready !== 1'b1) begin bad++; $display("[TB] FAIL bad_idx_ready_back got=%b want=1", m_bus.err_ready); end
   endtask

   task automatic test_reset_mid();
      snap_t obs, e;
      step();
      m_bus.err_valid = 1'b1; m_bus.err_qubit = 3'd2; m_bus.err_pauli = 2'b10;
      step();
      m_bus.err_valid = 1'b0;
      step();
      RST_N = 1'b0;
      step();
      RST_N = 1'b1;
      exp_cc = 0;
      total++; if ({m_rs, m_bus.err_ready, m_cc} !== {2'b11, 8'd0}) begin
         bad++; $display("[TB] FAIL reset_mid_state got=%b want=%b", {m_rs, m_bus.err_ready, m_cc}, {2'b11, 8'd0});
      end
      push_exp(5'd0, 5'd0, 4'b0000, 0);
      wait_round(1'b0, obs);
      e = exp_q.pop_front();
      total++; if (obs !== e) begin bad++; $display("[TB] FAIL reset_mid_frame got=%h want=%h", obs, e); end
   endtask

   task automatic test_saturate();
      snap_t obs, e;
      for (int i = 0; i < 260; i++) begin
         m_bus.err_valid = 1'b1; m_bus.err_qubit = 3'd0; m_bus.err_pauli = 2'b10;
         step();
         m_bus.err_valid = 1'b0;
         step();
         m_bus.axis = 2'b01; m_bus.correction = 5'b00001;
         step();
         m_bus.axis = 2'b00; m_bus.correction = 5'b00000;
         exp_cc = (exp_cc == 255) ? 255 : exp_cc + 1;
         push_exp(5'd0, 5'd0, 4'b0000, exp_cc);
         wait_round(1'b0, obs);
         e = exp_q.pop_front();
         total++; if (obs !== e) begin bad++; $display("[TB] FAIL saturate round=%0d got=%h want=%h", i, obs, e); end
      end
   endtask

   initial begin
      RST_N = 1'b0;
      m_bus.err_valid = 1'b0; m_bus.err_qubit = 3'd0; m_bus.err_pauli = 2'b00;
      m_bus.correction = 5'd0; m_bus.axis = 2'b00;
      o_bus.err_valid = 1'b0; o_bus.err_qubit = 3'd0; o_bus.err_pauli = 2'b00;
      o_bus.correction = 5'd0; o_bus.axis = 2'b00;
      test_reset();
      test_idle();
      test_loopback("loop_x", 3'd4, 2'b10, 5'b10000, 5'b00000, 4'b0001);
      test_loopback("loop_y", 3'd1, 2'b11, 5'b00010, 5'b00010, 4'b1111);
      test_open_loop();
      test_window();
      test_last_phase();
      test_bad_idx();
      test_reset_mid();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
